// File: rtl/writeback_stage.sv
// Writeback stage: retires memory-stage results into the register-file write port,
// splitting LDD double-word results into an even-register then an odd-register write.
module writeback_stage #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned REG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid,
    output logic                      wb_ready,
    input  logic [BUS_DATA_WIDTH-1:0] mem_data_in,
    input  logic [4:0]                mem_regD_in,
    input  logic                      mem_regWrite,
    input  logic                      mem_regWriteDouble,
    input  logic [3:0]                mem_icc_in,
    input  logic [3:0]                mem_icc_en,
    output logic                      WB_reg_en,
    output logic [REG_WIDTH-1:0]      WB_data_out,
    output logic [4:0]                WB_regD_out,
    output logic [3:0]                WB_icc_out,
    output logic [3:0]                WB_icc_en,
    output logic [4:0]                MemWB_regD_out,
    output logic                      MemWB_regWrite,
    output logic                      MemWB_regWriteDouble,
    output logic [31:0]               retired_count
);

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ICC_W      = 4;
    localparam int unsigned CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [BUS_DATA_WIDTH-1:0] hold_data;
    logic [REG_ADDR_W-1:0]     hold_rd;
    logic                      hold_regWrite;
    logic                      hold_double;
    logic [ICC_W-1:0]          hold_icc;
    logic [ICC_W-1:0]          hold_icc_en;

    logic                      accept;
    logic                      retire_c;
    logic [REG_ADDR_W-1:0]     rd_even;
    logic [REG_ADDR_W-1:0]     rd_odd;
    logic [REG_ADDR_W-1:0]     wr1_rd;
    logic [REG_WIDTH-1:0]      data_hi;
    logic [REG_WIDTH-1:0]      data_lo;

    // Pair addresses and word halves for the double-word sequence
    assign rd_even = {hold_rd[REG_ADDR_W-1:1], 1'b0};
    assign rd_odd  = {hold_rd[REG_ADDR_W-1:1], 1'b1};
    assign wr1_rd  = hold_double ? rd_even : hold_rd;
    assign data_hi = hold_data[BUS_DATA_WIDTH-1 -: REG_WIDTH];
    assign data_lo = hold_data[REG_WIDTH-1:0];

    assign accept   = mem_valid && wb_ready;
    assign retire_c = ((state == WR1) && !hold_double) || (state == WR2);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WR1;
                end
            end
            WR1: begin
                if (hold_double) begin
                    state_next = WR2;
                end else if (accept) begin
                    state_next = WR1;
                end else begin
                    state_next = IDLE;
                end
            end
            WR2: begin
                if (accept) begin
                    state_next = WR1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and hold registers
    always_comb begin
        wb_ready             = 1'b1;
        WB_reg_en            = 1'b0;
        WB_data_out          = '0;
        WB_regD_out          = '0;
        WB_icc_out           = '0;
        WB_icc_en            = '0;
        MemWB_regD_out       = '0;
        MemWB_regWrite       = 1'b0;
        MemWB_regWriteDouble = 1'b0;
        case (state)
            WR1: begin
                wb_ready             = !hold_double;
                WB_regD_out          = wr1_rd;
                WB_data_out          = hold_double ? data_hi : data_lo;
                WB_reg_en            = (hold_regWrite || hold_double) && (wr1_rd != '0);
                WB_icc_out           = hold_icc;
                WB_icc_en            = hold_icc_en;
                MemWB_regD_out       = wr1_rd;
                MemWB_regWrite       = hold_regWrite || hold_double;
                MemWB_regWriteDouble = hold_double;
            end
            WR2: begin
                WB_regD_out          = rd_odd;
                WB_data_out          = data_lo;
                WB_reg_en            = 1'b1;
                MemWB_regD_out       = rd_odd;
                MemWB_regWrite       = 1'b1;
                MemWB_regWriteDouble = 1'b0;
            end
            default: begin
                wb_ready = 1'b1;
            end
        endcase
    end

    // Capture the retiring instruction on a handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data     <= '0;
            hold_rd       <= '0;
            hold_regWrite <= 1'b0;
            hold_double   <= 1'b0;
            hold_icc      <= '0;
            hold_icc_en   <= '0;
        end else if (accept) begin
            hold_data     <= mem_data_in;
            hold_rd       <= mem_regD_in;
            hold_regWrite <= mem_regWrite;
            hold_double   <= mem_regWriteDouble;
            hold_icc      <= mem_icc_in;
            hold_icc_en   <= mem_icc_en;
        end
    end

    // Count instructions on their last write cycle; wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire_c) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random traffic
// compared every cycle against a queue-of-write-cycles reference model.
module tb_writeback_stage;

    typedef struct {
        bit          en;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  icc;
        logic [3:0]  icc_en;
        logic [4:0]  mrd;
        bit          mw;
        bit          mwd;
        bit          last;
    } wcyc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic        wb_ready;
    logic [63:0] mem_data_in = '0;
    logic [4:0]  mem_regD_in = '0;
    logic        mem_regWrite = 1'b0;
    logic        mem_regWriteDouble = 1'b0;
    logic [3:0]  mem_icc_in = '0;
    logic [3:0]  mem_icc_en = '0;
    logic        WB_reg_en;
    logic [31:0] WB_data_out;
    logic [4:0]  WB_regD_out;
    logic [3:0]  WB_icc_out;
    logic [3:0]  WB_icc_en;
    logic [4:0]  MemWB_regD_out;
    logic        MemWB_regWrite;
    logic        MemWB_regWriteDouble;
    logic [31:0] retired_count;

    writeback_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_valid           (mem_valid),
        .wb_ready            (wb_ready),
        .mem_data_in         (mem_data_in),
        .mem_regD_in         (mem_regD_in),
        .mem_regWrite        (mem_regWrite),
        .mem_regWriteDouble  (mem_regWriteDouble),
        .mem_icc_in          (mem_icc_in),
        .mem_icc_en          (mem_icc_en),
        .WB_reg_en           (WB_reg_en),
        .WB_data_out         (WB_data_out),
        .WB_regD_out         (WB_regD_out),
        .WB_icc_out          (WB_icc_out),
        .WB_icc_en           (WB_icc_en),
        .MemWB_regD_out      (MemWB_regD_out),
        .MemWB_regWrite      (MemWB_regWrite),
        .MemWB_regWriteDouble(MemWB_regWriteDouble),
        .retired_count       (retired_count)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: queue of future output cycles, current cycle, ready, count
    wcyc_t       q[$];
    wcyc_t       cur;
    bit          m_ready = 1'b1;
    logic [31:0] m_count = '0;

    function automatic wcyc_t idle_cyc();
        wcyc_t c;
        c.en = 0; c.data = '0; c.rd = '0; c.icc = '0; c.icc_en = '0;
        c.mrd = '0; c.mw = 0; c.mwd = 0; c.last = 0;
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("wb_ready", 64'(wb_ready), 64'(m_ready));
        chk("WB_reg_en", 64'(WB_reg_en), 64'(cur.en));
        chk("WB_data_out", 64'(WB_data_out), 64'(cur.data));
        chk("WB_regD_out", 64'(WB_regD_out), 64'(cur.rd));
        chk("WB_icc_out", 64'(WB_icc_out), 64'(cur.icc));
        chk("WB_icc_en", 64'(WB_icc_en), 64'(cur.icc_en));
        chk("MemWB_regD_out", 64'(MemWB_regD_out), 64'(cur.mrd));
        chk("MemWB_regWrite", 64'(MemWB_regWrite), 64'(cur.mw));
        chk("MemWB_regWriteDouble", 64'(MemWB_regWriteDouble), 64'(cur.mwd));
        chk("retired_count", 64'(retired_count), 64'(m_count));
    endtask

    // Expand an accepted instruction into the write cycles it must produce
    task automatic model_accept();
        wcyc_t c;
        logic [4:0] even;
        c = idle_cyc();
        even = mem_regD_in & 5'b11110;
        c.icc = mem_icc_in;
        c.icc_en = mem_icc_en;
        if (mem_regWriteDouble) begin
            c.rd = even; c.mrd = even; c.data = mem_data_in[63:32];
            c.en = (even != 5'd0); c.mw = 1; c.mwd = 1; c.last = 0;
            q.push_back(c);
            c = idle_cyc();
            c.rd = even + 5'd1; c.mrd = even + 5'd1; c.data = mem_data_in[31:0];
            c.en = 1; c.mw = 1; c.last = 1;
            q.push_back(c);
        end else begin
            c.rd = mem_regD_in; c.mrd = mem_regD_in; c.data = mem_data_in[31:0];
            c.en = mem_regWrite && (mem_regD_in != 5'd0); c.mw = mem_regWrite;
            c.last = 1;
            q.push_back(c);
        end
    endtask

    // Advance one clock, update the model, check all outputs just after the edge
    task automatic step();
        bit acc;
        @(posedge clk);
        acc = mem_valid && m_ready;
        if (cur.last) m_count = m_count + 32'd1;
        if (acc) model_accept();
        cur = (q.size() > 0) ? q.pop_front() : idle_cyc();
        m_ready = (q.size() == 0);
        #1;
        check_model();
    endtask

    // Pulse reset mid-cycle and check the asynchronous clear
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        cur = idle_cyc();
        m_ready = 1'b1;
        m_count = '0;
        check_model();
        chk("rst_ready_lit", 64'(wb_ready), 64'd1);
        chk("rst_count_lit", 64'(retired_count), 64'd0);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [4:0] rd, input logic [63:0] d,
                         input bit rw, input bit dbl, input logic [3:0] icc,
                         input logic [3:0] ien);
        mem_valid = v; mem_regD_in = rd; mem_data_in = d; mem_regWrite = rw;
        mem_regWriteDouble = dbl; mem_icc_in = icc; mem_icc_en = ien;
    endtask

    initial begin
        cur = idle_cyc();
        do_reset();

        // Single write
        drive(1, 5'd5, 64'h0000_0000_DEAD_BEEF, 1, 0, 4'h0, 4'h0);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        chk("single_en", 64'(WB_reg_en), 64'd1);
        chk("single_rd", 64'(WB_regD_out), 64'd5);
        chk("single_data", 64'(WB_data_out), 64'hDEADBEEF);
        chk("single_memwb_rd", 64'(MemWB_regD_out), 64'd5);
        step();
        chk("single_count", 64'(retired_count), 64'd1);

        // LDD to r8/r9
        drive(1, 5'd8, 64'h1111_2222_3333_4444, 0, 1, 4'h0, 4'h0);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        chk("ldd1_rd", 64'(WB_regD_out), 64'd8);
        chk("ldd1_data", 64'(WB_data_out), 64'h11112222);
        chk("ldd1_ready", 64'(wb_ready), 64'd0);
        step();
        chk("ldd2_rd", 64'(WB_regD_out), 64'd9);
        chk("ldd2_data", 64'(WB_data_out), 64'h33334444);
        chk("ldd2_ready", 64'(wb_ready), 64'd1);
        step();
        chk("ldd_count", 64'(retired_count), 64'd2);

        // Back-to-back singles
        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'(i), 64'(i * 16'h1010), 1, 0, 4'h0, 4'h0);
            step();
            chk("b2b_rd", 64'(WB_regD_out), 64'(i));
            chk("b2b_ready", 64'(wb_ready), 64'd1);
        end
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        step();
        chk("b2b_idle_memwb", 64'(MemWB_regWrite), 64'd0);

        // r0 write suppressed, icc pulse
        drive(1, 5'd0, 64'h1234, 1, 0, 4'b0100, 4'b1111);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        chk("r0_en", 64'(WB_reg_en), 64'd0);
        chk("r0_icc_en", 64'(WB_icc_en), 64'hF);
        chk("r0_icc", 64'(WB_icc_out), 64'h4);
        step();
        chk("r0_icc_en_drop", 64'(WB_icc_en), 64'd0);

        // LDD rd=0 still writes r1
        drive(1, 5'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1, 4'h0, 4'h0);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        chk("ldd0_en1", 64'(WB_reg_en), 64'd0);
        step();
        chk("ldd0_en2", 64'(WB_reg_en), 64'd1);
        chk("ldd0_rd2", 64'(WB_regD_out), 64'd1);
        step();

        // Reset in WR2 of LDD to r10, then a normal write to r4
        drive(1, 5'd10, 64'h5555_6666_7777_8888, 0, 1, 4'h0, 4'h0);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        step();
        chk("r11_pending", 64'(WB_regD_out), 64'd11);
        drive(1, 5'd4, 64'h0000_0000_0404_0404, 1, 0, 4'h0, 4'h0);
        do_reset();
        chk("r11_discard", 64'(WB_reg_en), 64'd0);
        step();
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        chk("after_rst_rd", 64'(WB_regD_out), 64'd4);
        chk("after_rst_en", 64'(WB_reg_en), 64'd1);
        step();
        chk("after_rst_count", 64'(retired_count), 64'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, 5'($urandom), {$urandom, $urandom},
                  1'($urandom), $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end
        drive(0, 5'd0, 64'h0, 0, 0, 4'h0, 4'h0);
        for (int n = 0; n < 4; n++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
